// File: rtl/vga_timing_gen_if.sv
// Bundle of raster timing signals passed from the timing generator to the pixel pipeline.
// The master drives position, sync and strobes; the slave supplies the pixel advance enable.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
) ();
  logic             en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] fetch_x;
  logic [CNT_W-1:0] fetch_y;
  logic             h_sync;
  logic             v_sync;
  logic             blank;
  logic             de;
  logic             line_start;
  logic             frame_start;
  logic             vblank_start;

  modport master (
    input  en,
    output h_cnt, v_cnt, fetch_x, fetch_y,
    output h_sync, v_sync, blank, de,
    output line_start, frame_start, vblank_start
  );

  modport slave (
    output en,
    input  h_cnt, v_cnt, fetch_x, fetch_y,
    input  h_sync, v_sync, blank, de,
    input  line_start, frame_start, vblank_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: beam position, look-ahead fetch position,
// sync/blank decodes and line/frame/vblank strobes, all registered.
module vga_timing_gen #(
  parameter int CNT_W      = 10,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int LOOKAHEAD  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  vga_timing_gen_if.master        bus
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CNT_RANGE = 1 << CNT_W;

  generate
    if (H_TOTAL > CNT_RANGE || V_TOTAL > CNT_RANGE) begin : g_badCntW
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL) begin : g_badLookahead
      $error("vga_timing_gen: LOOKAHEAD must be in [0, H_TOTAL)");
    end
  endgenerate

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t x;
    cnt_t y;
  } pos_t;

  localparam cnt_t H_LAST      = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS       = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS       = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST    = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_LAST     = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST    = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_LAST     = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam cnt_t FETCH_RESET = cnt_t'(LOOKAHEAD);

  // One raster step: column wraps at the end of the line and carries into the line count.
  function automatic pos_t stepPos(input pos_t p);
    pos_t n;
    n = p;
    if (p.x == H_LAST) begin
      n.x = '0;
      n.y = (p.y == V_LAST) ? '0 : p.y + 1'b1;
    end else begin
      n.x = p.x + 1'b1;
    end
    return n;
  endfunction

  logic r_hSync;
  logic r_vSync;
  logic r_blank;
  logic r_de;
  logic r_lineStart;
  logic r_frameStart;
  logic r_vblankStart;
  pos_t r_beam;
  pos_t r_fetch;

  pos_t w_beamNext;
  pos_t w_fetchNext;
  logic w_hSyncNext;
  logic w_vSyncNext;
  logic w_blankNext;
  logic w_lineStartNext;
  logic w_vblankNext;

  // Decodes are taken from the position about to be loaded so they line up with it.
  always_comb begin
    w_beamNext      = stepPos(r_beam);
    w_fetchNext     = stepPos(r_fetch);
    w_hSyncNext     = ~H_SYNC_POL;
    w_vSyncNext     = ~V_SYNC_POL;
    w_blankNext     = 1'b1;
    w_lineStartNext = 1'b0;
    w_vblankNext    = 1'b0;

    if (w_beamNext.x >= HS_FIRST && w_beamNext.x <= HS_LAST) begin
      w_hSyncNext = H_SYNC_POL;
    end
    if (w_beamNext.y >= VS_FIRST && w_beamNext.y <= VS_LAST) begin
      w_vSyncNext = V_SYNC_POL;
    end
    if (w_beamNext.x < H_VIS && w_beamNext.y < V_VIS) begin
      w_blankNext = 1'b0;
    end
    if (w_beamNext.x == '0) begin
      w_lineStartNext = 1'b1;
      w_vblankNext    = (w_beamNext.y == V_VIS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beam  <= '0;
      r_fetch <= '{x: FETCH_RESET, y: '0};
      r_hSync <= ~H_SYNC_POL;
      r_vSync <= ~V_SYNC_POL;
      r_blank <= 1'b0;
      r_de    <= 1'b1;
    end else if (bus.en) begin
      r_beam  <= w_beamNext;
      r_fetch <= w_fetchNext;
      r_hSync <= w_hSyncNext;
      r_vSync <= w_vSyncNext;
      r_blank <= w_blankNext;
      r_de    <= ~w_blankNext;
    end
  end

  // Strobes fire only on an enabled step, so they never stretch while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lineStart   <= 1'b0;
      r_frameStart  <= 1'b0;
      r_vblankStart <= 1'b0;
    end else begin
      r_lineStart   <= bus.en & w_lineStartNext;
      r_frameStart  <= bus.en & w_lineStartNext & (w_beamNext.y == '0);
      r_vblankStart <= bus.en & w_vblankNext;
    end
  end

  assign bus.h_cnt        = r_beam.x;
  assign bus.v_cnt        = r_beam.y;
  assign bus.fetch_x      = r_fetch.x;
  assign bus.fetch_y      = r_fetch.y;
  assign bus.h_sync       = r_hSync;
  assign bus.v_sync       = r_vSync;
  assign bus.blank        = r_blank;
  assign bus.de           = r_de;
  assign bus.line_start   = r_lineStart;
  assign bus.frame_start  = r_frameStart;
  assign bus.vblank_start = r_vblankStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations share one stimulus stream and are
// compared cycle by cycle against a position model through per-instance expectation queues.
module tb_vga_timing_gen;

  typedef struct {
    int hVis, hFront, hSync, hBack;
    int vVis, vFront, vSync, vBack;
    bit hPol, vPol;
    int look;
  } cfgT;

  typedef struct {
    int h;
    int v;
  } posT;

  typedef struct {
    logic [31:0] h, v, fx, fy;
    logic        hs, vs, blank, de, ls, fs, vbs;
  } vecT;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(10)) busA ();
  vga_timing_gen_if #(.CNT_W(10)) busB ();
  vga_timing_gen_if #(.CNT_W(9))  busC ();

  assign busA.en = en;
  assign busB.en = en;
  assign busC.en = en;

  vga_timing_gen #(.CNT_W(10)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.master)
  );

  vga_timing_gen #(
    .CNT_W(10), .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .LOOKAHEAD(8)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.master)
  );

  vga_timing_gen #(
    .CNT_W(9), .H_VISIBLE(256), .H_FRONT(8), .H_SYNC(32), .H_BACK(40),
    .V_VISIBLE(10), .V_FRONT(4), .V_SYNC(3), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dutC (
    .clk (clk),
    .rst (rst),
    .bus (busC.master)
  );

  cfgT cfgA, cfgB, cfgC;
  posT pA, pB, pC;
  vecT qA[$], qB[$], qC[$];

  int tests = 0;
  int errors = 0;
  bit abortRun = 0;
  int cyc = 0;
  int linePeriodA = 0, lastLineA = -1;
  int framePeriodB = 0, lastFrameB = -1;
  int framePeriodC = 0, lastFrameC = -1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      if (errors >= 40 && !abortRun) begin
        abortRun = 1;
        $display("[TB] too many errors, stopping early");
      end
    end
  endtask

  function automatic posT stepPos(input cfgT c, input posT p, input logic enV, input logic rstV);
    posT n = p;
    int hTot = c.hVis + c.hFront + c.hSync + c.hBack;
    int vTot = c.vVis + c.vFront + c.vSync + c.vBack;
    if (rstV) begin
      n.h = 0;
      n.v = 0;
    end else if (enV) begin
      n.h = p.h + 1;
      if (n.h == hTot) begin
        n.h = 0;
        n.v = p.v + 1;
        if (n.v == vTot) n.v = 0;
      end
    end
    return n;
  endfunction

  function automatic vecT decode(input cfgT c, input posT p, input logic stepped);
    vecT e;
    int hTot = c.hVis + c.hFront + c.hSync + c.hBack;
    int vTot = c.vVis + c.vFront + c.vSync + c.vBack;
    int lin = (p.v * hTot + p.h + c.look) % (hTot * vTot);
    bit hsAct = (p.h >= c.hVis + c.hFront) && (p.h < c.hVis + c.hFront + c.hSync);
    bit vsAct = (p.v >= c.vVis + c.vFront) && (p.v < c.vVis + c.vFront + c.vSync);
    e.h     = 32'(p.h);
    e.v     = 32'(p.v);
    e.fx    = 32'(lin % hTot);
    e.fy    = 32'(lin / hTot);
    e.hs    = hsAct ? c.hPol : !c.hPol;
    e.vs    = vsAct ? c.vPol : !c.vPol;
    e.blank = !(p.h < c.hVis && p.v < c.vVis);
    e.de    = !e.blank;
    e.ls    = stepped && p.h == 0;
    e.fs    = stepped && p.h == 0 && p.v == 0;
    e.vbs   = stepped && p.h == 0 && p.v == c.vVis;
    return e;
  endfunction

  function automatic vecT sampleA();
    vecT o;
    o.h = 32'(busA.h_cnt);  o.v = 32'(busA.v_cnt);
    o.fx = 32'(busA.fetch_x); o.fy = 32'(busA.fetch_y);
    o.hs = busA.h_sync; o.vs = busA.v_sync; o.blank = busA.blank; o.de = busA.de;
    o.ls = busA.line_start; o.fs = busA.frame_start; o.vbs = busA.vblank_start;
    return o;
  endfunction

  function automatic vecT sampleB();
    vecT o;
    o.h = 32'(busB.h_cnt);  o.v = 32'(busB.v_cnt);
    o.fx = 32'(busB.fetch_x); o.fy = 32'(busB.fetch_y);
    o.hs = busB.h_sync; o.vs = busB.v_sync; o.blank = busB.blank; o.de = busB.de;
    o.ls = busB.line_start; o.fs = busB.frame_start; o.vbs = busB.vblank_start;
    return o;
  endfunction

  function automatic vecT sampleC();
    vecT o;
    o.h = 32'(busC.h_cnt);  o.v = 32'(busC.v_cnt);
    o.fx = 32'(busC.fetch_x); o.fy = 32'(busC.fetch_y);
    o.hs = busC.h_sync; o.vs = busC.v_sync; o.blank = busC.blank; o.de = busC.de;
    o.ls = busC.line_start; o.fs = busC.frame_start; o.vbs = busC.vblank_start;
    return o;
  endfunction

  task automatic compareVec(input string pfx, input vecT o, input vecT e);
    checkOutput({pfx, "h_cnt"},        o.h,         e.h);
    checkOutput({pfx, "v_cnt"},        o.v,         e.v);
    checkOutput({pfx, "fetch_x"},      o.fx,        e.fx);
    checkOutput({pfx, "fetch_y"},      o.fy,        e.fy);
    checkOutput({pfx, "h_sync"},       32'(o.hs),    32'(e.hs));
    checkOutput({pfx, "v_sync"},       32'(o.vs),    32'(e.vs));
    checkOutput({pfx, "blank"},        32'(o.blank), 32'(e.blank));
    checkOutput({pfx, "de"},           32'(o.de),    32'(e.de));
    checkOutput({pfx, "line_start"},   32'(o.ls),    32'(e.ls));
    checkOutput({pfx, "frame_start"},  32'(o.fs),    32'(e.fs));
    checkOutput({pfx, "vblank_start"}, 32'(o.vbs),   32'(e.vbs));
  endtask

  // Pops the expectations for the edge just taken and adds fixed-value boundary checks.
  task automatic compareAll();
    vecT e, o;
    cyc++;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      o = sampleA();
      compareVec("A.", o, e);
      if (e.h == 655) checkOutput("A.hsync_655", 32'(o.hs), 32'd1);
      if (e.h == 656) checkOutput("A.hsync_656", 32'(o.hs), 32'd0);
      if (e.h == 751) checkOutput("A.hsync_751", 32'(o.hs), 32'd0);
      if (e.h == 752) checkOutput("A.hsync_752", 32'(o.hs), 32'd1);
      if (e.h == 639) checkOutput("A.blank_639", 32'(o.blank), 32'd0);
      if (e.h == 640) checkOutput("A.blank_640", 32'(o.blank), 32'd1);
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      o = sampleB();
      compareVec("B.", o, e);
      if (e.h == 795 && e.v == 10) begin
        checkOutput("B.fetch_x_795_10", o.fx, 32'd3);
        checkOutput("B.fetch_y_795_10", o.fy, 32'd11);
      end
      if (e.h == 799 && e.v == 17) begin
        checkOutput("B.fetch_x_799_17", o.fx, 32'd7);
        checkOutput("B.fetch_y_799_17", o.fy, 32'd0);
      end
      if (e.h == 0 && e.v == 13) checkOutput("B.vsync_13", 32'(o.vs), 32'd1);
      if (e.h == 0 && e.v == 14) checkOutput("B.vsync_14", 32'(o.vs), 32'd0);
      if (e.h == 0 && e.v == 15) checkOutput("B.vsync_15", 32'(o.vs), 32'd0);
      if (e.h == 0 && e.v == 16) checkOutput("B.vsync_16", 32'(o.vs), 32'd1);
      if (e.h == 0 && e.v == 12 && e.ls) checkOutput("B.vblank_at_0_12", 32'(o.vbs), 32'd1);
    end
    if (qC.size() > 0) begin
      e = qC.pop_front();
      o = sampleC();
      compareVec("C.", o, e);
      if (e.h == 263) checkOutput("C.hsync_263", 32'(o.hs), 32'd0);
      if (e.h == 264) checkOutput("C.hsync_264", 32'(o.hs), 32'd1);
      if (e.h == 295) checkOutput("C.hsync_295", 32'(o.hs), 32'd1);
      if (e.h == 296) checkOutput("C.hsync_296", 32'(o.hs), 32'd0);
      if (e.h == 0 && e.v == 13) checkOutput("C.vsync_13", 32'(o.vs), 32'd0);
      if (e.h == 0 && e.v == 14) checkOutput("C.vsync_14", 32'(o.vs), 32'd1);
      if (e.h == 0 && e.v == 16) checkOutput("C.vsync_16", 32'(o.vs), 32'd1);
      if (e.h == 0 && e.v == 17) checkOutput("C.vsync_17", 32'(o.vs), 32'd0);
    end
    if (linePeriodA != 0 && busA.line_start === 1'b1) begin
      if (lastLineA >= 0) checkOutput("A.line_period", 32'(cyc - lastLineA), 32'(linePeriodA));
      lastLineA = cyc;
    end
    if (framePeriodB != 0 && busB.frame_start === 1'b1) begin
      if (lastFrameB >= 0) checkOutput("B.frame_period", 32'(cyc - lastFrameB), 32'(framePeriodB));
      lastFrameB = cyc;
    end
    if (framePeriodC != 0 && busC.frame_start === 1'b1) begin
      if (lastFrameC >= 0) checkOutput("C.frame_period", 32'(cyc - lastFrameC), 32'(framePeriodC));
      lastFrameC = cyc;
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic rstV);
    @(negedge clk);
    compareAll();
    en  = enV;
    rst = rstV;
    pA = stepPos(cfgA, pA, enV, rstV);
    pB = stepPos(cfgB, pB, enV, rstV);
    pC = stepPos(cfgC, pC, enV, rstV);
    qA.push_back(decode(cfgA, pA, enV && !rstV));
    qB.push_back(decode(cfgB, pB, enV && !rstV));
    qC.push_back(decode(cfgC, pC, enV && !rstV));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int steps;
    bit seen;
    en  = 1'b0;
    rst = 1'b0;
    cfgA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
    cfgB = '{640, 16, 96, 48, 12, 2, 2, 2, 1'b0, 1'b0, 8};
    cfgC = '{256, 8, 32, 40, 10, 4, 3, 3, 1'b1, 1'b1, 0};
    pA = '{0, 0};
    pB = '{0, 0};
    pC = '{0, 0};

    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (6) applyStimulus(1'b0, 1'b0);

    linePeriodA  = 800;   lastLineA  = -1;
    framePeriodB = 14400; lastFrameB = -1;
    framePeriodC = 6720;  lastFrameC = -1;
    for (int i = 0; i < 29500 && !abortRun; i++) applyStimulus(1'b1, 1'b0);

    framePeriodB = 0;
    framePeriodC = 0;
    linePeriodA  = 1600;
    lastLineA    = -1;
    for (int i = 0; i < 4000 && !abortRun; i++) applyStimulus((i % 2) == 0, 1'b0);

    linePeriodA = 800;
    lastLineA   = -1;
    for (int i = 0; i < 20000 && !(pB.h == 300 && pB.v == 5) && !abortRun; i++)
      applyStimulus(1'b1, 1'b0);

    // Reset asserted together with en at (300,5); reset must win.
    applyStimulus(1'b1, 1'b1);
    lastLineA = -1;
    steps = -1;
    seen  = 0;
    for (int k = 1; k <= 1200 && !seen && !abortRun; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (k == 1) checkOutput("B.no_frame_start_after_reset", 32'(busB.frame_start), 32'd0);
      if (busB.line_start === 1'b1) begin
        seen  = 1;
        steps = k - 1;
      end
    end
    checkOutput("B.first_line_after_reset", 32'(steps), 32'd800);

    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator. It produces pixel coordinates, sync, blank/data-enable and event strobes for any VGA-style mode, with selectable sync polarity and a look-ahead coordinate pair so the pixel pipeline can fetch ahead of the beam. It sits between the pixel-clock domain and the NES picture renderer and scaler. It also supplies the vblank strobe used to raise the emulated PPU NMI.

## Interface
Parameters:
- `CNT_W`, 10, width of all coordinate counters; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BACK`, 48, horizontal back porch, in pixels
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BACK`, 33, vertical back porch, in lines
- `H_SYNC_POL`, 0, active level of `h_sync` (0 = negative)
- `V_SYNC_POL`, 0, active level of `v_sync`
- `LOOKAHEAD`, 0, how far `fetch_x`/`fetch_y` lead `h_cnt`/`v_cnt`, in counted pixels; must satisfy 0 ≤ `LOOKAHEAD` < `H_TOTAL`
- Derived values: `H_TOTAL` = sum of the four H parameters (800); `V_TOTAL` = sum of the four V parameters (525)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  pixel advance enable; the counters step only when `en`=1
- `h_cnt`  out  CNT_W  current column, 0..H_TOTAL-1
- `v_cnt`  out  CNT_W  current line, 0..V_TOTAL-1
- `fetch_x`  out  CNT_W  column `LOOKAHEAD` positions ahead of `h_cnt`
- `fetch_y`  out  CNT_W  line of that look-ahead position
- `h_sync`  out  1  horizontal sync, polarity `H_SYNC_POL`
- `v_sync`  out  1  vertical sync, polarity `V_SYNC_POL`
- `blank`  out  1  1 outside the visible area
- `de`  out  1  data enable, equal to ~`blank`
- `line_start`  out  1  one-cycle strobe when a new line begins
- `frame_start`  out  1  one-cycle strobe when a new frame begins
- `vblank_start`  out  1  one-cycle strobe when vertical blanking begins

## Operation
- Counters:
  - When `en`=1, `h_cnt` increments.
  - At `H_TOTAL-1`, `h_cnt` wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps to 0 after `V_TOTAL-1`.
  - When `en`=0, all counters and levels hold.
- Look-ahead pair: `fetch_x`/`fetch_y` is an independent counter pair with the same wrap rules and the same `en` gating. Reset loads it with (`LOOKAHEAD`, 0), so it always equals the main position advanced by `LOOKAHEAD` steps, including the carry into the next line and the wrap into the next frame.
- Horizontal sync: active while `h_cnt` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. Inactive level is the complement of `H_SYNC_POL`.
- Vertical sync: active for whole lines while `v_cnt` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
- Blanking: `blank` = 1 unless (`h_cnt` < H_VISIBLE and `v_cnt` < V_VISIBLE).
- Strobes:
  - `line_start` is high in the first cycle in which `h_cnt`=0 after a step.
  - `frame_start` is the same, but additionally requires `v_cnt`=0.
  - `vblank_start` is high in the first cycle of position (0, V_VISIBLE).
  - Each strobe lasts exactly one clock, even if `en` stays low afterwards.
- Reset values:
  - `h_cnt`=0, `v_cnt`=0
  - `fetch_x`=LOOKAHEAD, `fetch_y`=0
  - `h_sync`=~H_SYNC_POL, `v_sync`=~V_SYNC_POL
  - `blank`=0, `de`=1
  - all strobes 0
- Reset mid-frame: in the next cycle every output takes its reset value, and counting restarts from (0,0) without a `frame_start` strobe.
- Parameter sanity: the block elaborates only if `H_TOTAL` ≤ 2^CNT_W and `V_TOTAL` ≤ 2^CNT_W; otherwise it stops with a generate-time error.

## Timing
- Every output is a register.
- `h_sync`, `v_sync`, `blank` and `de` are decoded from the next-state position, so they are cycle-aligned with the `h_cnt`/`v_cnt` values presented in the same cycle. There is no extra pipeline offset.
- From `en`=1 at edge N, the new position and all its decodes are visible after edge N.
- `rst` takes priority over `en` when both are high.
- Line period is `H_TOTAL` enabled cycles; frame period is `H_TOTAL`×`V_TOTAL` enabled cycles.

## Test plan
- Reset check: hold `rst` for 3 cycles, then release with `en`=0.
  - Required: `h_cnt`=`v_cnt`=0, `h_sync`=`v_sync`=1, `blank`=0, `de`=1, all strobes 0, and outputs stay constant.
- Default mode, `en`=1 continuously:
  - `h_sync` is low exactly for `h_cnt` 656..751.
  - `blank` rises at `h_cnt`=640.
  - `line_start` repeats every 800 cycles.
  - `v_sync` is low for lines 490..491.
  - `vblank_start` occurs at (0,480).
  - `frame_start` repeats every 420000 cycles.
- Enable gating: `en` toggling 1,0,1,0.
  - Required: `line_start` period of 1600 clocks, each strobe 1 clock wide.
  - Required: `h_cnt` never skips or repeats a value across enabled cycles.
- Look-ahead with LOOKAHEAD=8:
  - At `h_cnt`=795, `v_cnt`=10, require `fetch_x`=3 and `fetch_y`=11.
  - At (799,524), require `fetch_x`=7 and `fetch_y`=0.
- Mid-frame reset: pulse `rst` at (300,200).
  - Next cycle: all reset values, no `frame_start`.
  - The first `line_start` follows exactly 800 enabled cycles later.
- Alternate mode: H 256/8/32/40, V 240/4/3/15, both polarities 1, CNT_W=9.
  - `h_sync` is high for h 264..295 and low otherwise.
  - `v_sync` is high for lines 244..246.
  - Frame period is 336×262 = 88032 cycles.
